// File: rtl/router_fifo_pkg.sv
// Shared router FIFO definitions: lane geometry and packed-bus helpers.
package router_fifo_pkg;

    localparam int unsigned FLIT_W     = 256;
    localparam int unsigned LANES      = 4;
    localparam int unsigned FIFO_DEPTH = 128;

    typedef logic [$clog2(LANES)-1:0] lane_idx_t;

    // Low bit of slot idx in a bus of w-bit slots, for [lo +: w] selects.
    function automatic int unsigned slice_lo(input int unsigned idx,
                                             input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/lane_fifo_core.sv
// One FWFT lane: storage, wrapping pointers, occupancy, flags and flush.
module lane_fifo_core
    import router_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FLIT_W,
    parameter int unsigned DEPTH      = FIFO_DEPTH,
    parameter int unsigned AF_THRESH  = DEPTH - 4,
    localparam int unsigned PW        = $clog2(DEPTH),
    localparam int unsigned CW        = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  flush,
    output logic                  full,
    output logic                  almost_full,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Flush wins over both handshakes on the same edge.
    assign w_push = in_valid & ~w_full & ~flush;
    assign w_pop  = out_ready & ~w_empty & ~flush;

    assign in_ready    = ~w_full;
    assign out_valid   = ~w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= CW'(AF_THRESH));
    assign count       = r_count;

    // Gated so an empty lane never exposes uninitialised storage.
    assign out_data = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lane_fifo_bank.sv
// Bank of independent FWFT lane FIFOs between router inputs and crossbar.
module lane_fifo_bank
    import router_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FLIT_W,
    parameter int unsigned DEPTH      = FIFO_DEPTH,
    parameter int unsigned NUM_LANES  = LANES,
    parameter int unsigned AF_THRESH  = DEPTH - 4,
    localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_LANES-1:0]            in_valid,
    output logic [NUM_LANES-1:0]            in_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
    output logic [NUM_LANES-1:0]            out_valid,
    input  logic [NUM_LANES-1:0]            out_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
    input  logic [NUM_LANES-1:0]            flush,
    output logic [NUM_LANES-1:0]            full,
    output logic [NUM_LANES-1:0]            almost_full,
    output logic [NUM_LANES*CW-1:0]         count
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int unsigned DLO = slice_lo(i, DATA_WIDTH);
        localparam int unsigned CLO = slice_lo(i, CW);

        lane_fifo_core #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .AF_THRESH  (AF_THRESH)
        ) u_core (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (in_valid[i]),
            .in_ready    (in_ready[i]),
            .in_data     (in_data[DLO +: DATA_WIDTH]),
            .out_valid   (out_valid[i]),
            .out_ready   (out_ready[i]),
            .out_data    (out_data[DLO +: DATA_WIDTH]),
            .flush       (flush[i]),
            .full        (full[i]),
            .almost_full (almost_full[i]),
            .count       (count[CLO +: CW])
        );
    end

endmodule
